// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage sitting directly after the program
//                counter. Issues one instruction-memory read at a time over a
//                req/ack handshake, steps the PC on each completed read and
//                buffers fetched words in a small queue toward the decoder
//                (valid/ready). A jump redirect from execute reloads the PC,
//                flushes the queue and discards any read still in flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk_i            rising-edge clock
//   reset_i          asynchronous active-high reset (shared with the PC)
//   pc_addr_i        current program counter value
//   pc_in_o          PC load value (= redirect_addr_i)
//   pc_load_o        PC load strobe
//   pc_inc_o         PC increment strobe
//   mem_req_o        memory read request (registered)
//   mem_addr_o       memory read address (registered, stable while requesting)
//   mem_ack_i        one-cycle pulse: mem_rdata_i valid, request complete
//   mem_rdata_i      memory read data
//   instr_o          queue head instruction
//   instr_pc_o       address of the queue head instruction
//   instr_valid_o    queue non-empty
//   instr_ready_i    decoder accepts the head this cycle
//   redirect_i       jump taken: flush and restart at redirect_addr_i
//   redirect_addr_i  jump target
// ============================================================================
module instr_fetch #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] pc_addr_i,
   output logic [WIDTH-1:0] pc_in_o,
   output logic             pc_load_o,
   output logic             pc_inc_o,
   output logic             mem_req_o,
   output logic [WIDTH-1:0] mem_addr_o,
   input  logic             mem_ack_i,
   input  logic [WIDTH-1:0] mem_rdata_i,
   output logic [WIDTH-1:0] instr_o,
   output logic [WIDTH-1:0] instr_pc_o,
   output logic             instr_valid_o,
   input  logic             instr_ready_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_addr_i
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t              state_q;
   logic                mem_req_q;
   logic [WIDTH-1:0]    mem_addr_q;

   logic [WIDTH-1:0]    data_q [DEPTH];
   logic [WIDTH-1:0]    addr_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q,  count_d;

   logic                push_w;
   logic                pop_w;

   // A completed read is kept only if it belongs to the live request stream;
   // an ack landing together with a redirect is thrown away.
   assign push_w = (state_q == ST_REQ) && mem_ack_i && !redirect_i;
   assign pop_w  = (count_q != '0) && instr_ready_i;

   // PC controls; suppressed while reset is held so the PC only sees reset.
   assign pc_in_o   = redirect_addr_i;
   assign pc_load_o = redirect_i && !reset_i;
   assign pc_inc_o  = push_w && !reset_i;

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = mem_addr_q;
   assign instr_valid_o = (count_q != '0);
   assign instr_o       = data_q[rd_ptr_q];
   assign instr_pc_o    = addr_q[rd_ptr_q];

   // Queue bookkeeping; a redirect flush wins over any same-cycle push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_w) begin
            data_q[wr_ptr_q] <= mem_rdata_i;
            addr_q[wr_ptr_q] <= mem_addr_q;
         end
      end
   end

   // Fetch FSM. Issuing only from IDLE with a free slot guarantees the queue
   // can never overflow, since at most one read is ever outstanding.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!redirect_i && (count_q < FULL_CNT)) begin
                  state_q    <= ST_REQ;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= pc_addr_i;
               end
            end
            ST_REQ: begin
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (redirect_i) begin
                  // Request cannot be withdrawn; wait for it and discard.
                  state_q <= ST_DROP;
               end
            end
            ST_DROP: begin
               if (mem_ack_i) begin
                  mem_req_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
